// File: rtl/add_round_key_serial_if.sv
// Valid/ready bundle for the lane-serial AddRoundKey stage: state+key in, result out.
interface add_round_key_serial_if #(
   parameter int BLOCK_W = 128
);
   logic               in_valid;
   logic               in_ready;
   logic [BLOCK_W-1:0] in_data;
   logic [BLOCK_W-1:0] in_key;
   logic               in_bypass;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] out_data;
   logic               busy;

   modport master (
      output in_valid, in_data, in_key, in_bypass, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_key, in_bypass, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/add_round_key_serial.sv
// Lane-serial AddRoundKey: latches one state/key pair, XORs LANE_W bits per clock,
// then holds the finished block until the consumer takes it.
module add_round_key_serial #(
   parameter int BLOCK_W = 128,
   parameter int LANE_W  = 32
) (
   input logic                   clk,
   input logic                   n_rst,
   add_round_key_serial_if.slave bus
);
   localparam int BEATS = BLOCK_W / LANE_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [BLOCK_W-1:0] data_q, data_d;
   logic [BLOCK_W-1:0] key_q, key_d;
   logic               bypass_q, bypass_d;
   logic [BLOCK_W-1:0] out_data_q, out_data_d;
   logic               accept;
   logic [LANE_W-1:0]  lane_xor [BEATS];

   // Gated by n_rst so nothing is offered upstream while reset is held.
   assign bus.in_ready  = n_rst & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q == BUSY);
   assign bus.out_data  = out_data_q;
   assign accept        = bus.in_valid & bus.in_ready;

   for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
      assign lane_xor[gi] = data_q[gi*LANE_W +: LANE_W]
                          ^ (bypass_q ? {LANE_W{1'b0}} : key_q[gi*LANE_W +: LANE_W]);
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      data_d     = data_q;
      key_d      = key_q;
      bypass_d   = bypass_q;
      out_data_d = out_data_q;

      case (state_q)
         IDLE: ;
         BUSY: begin
            for (int i = 0; i < BEATS; i++) begin
               if (beat_cnt_q == CNT_W'(i)) begin
                  out_data_d[i*LANE_W +: LANE_W] = lane_xor[i];
               end
            end
            if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
               beat_cnt_d = '0;
               state_d    = DONE;
            end else begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new block can only arrive from IDLE or a consumed DONE; it overrides the above.
      if (accept) begin
         data_d     = bus.in_data;
         key_d      = bus.in_key;
         bypass_d   = bus.in_bypass;
         beat_cnt_d = '0;
         out_data_d = '0;
         state_d    = BUSY;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         data_q     <= '0;
         key_q      <= '0;
         bypass_q   <= 1'b0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         data_q     <= data_d;
         key_q      <= key_d;
         bypass_q   <= bypass_d;
         out_data_q <= out_data_d;
      end
   end
endmodule
